// File: rtl/wb_pkg.sv
// Shared types for the GPR writeback controller: source-select encodings, FSM states, default width.
package wb_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    SEL_ALU    = 3'd0,
    SEL_PC_OUT = 3'd1,
    SEL_IMM    = 3'd2,
    SEL_PC_SEQ = 3'd3,
    SEL_CSR    = 3'd4,
    SEL_MEM    = 3'd5
  } wb_sel_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wb_state_e;

  // x0 is hardwired to zero, so only a non-zero rd with wen set produces a real write.
  function automatic logic rd_writes(input logic wen, input logic [4:0] rd);
    return wen & (rd != 5'd0);
  endfunction

endpackage

// File: rtl/wb_data_mux.sv
// Combinational rd data source select for non-load instructions; load data arrives later from the LSU.
module wb_data_mux
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      sel,
  input  logic [XLEN-1:0] alu_data,
  input  logic [XLEN-1:0] alu_pc_out,
  input  logic [XLEN-1:0] imme,
  input  logic [XLEN-1:0] alu_pc_seq,
  input  logic [XLEN-1:0] csr_data,
  output logic [XLEN-1:0] data
);

  always_comb begin
    data = alu_data;
    case (sel)
      SEL_PC_OUT: data = alu_pc_out;
      SEL_IMM:    data = imme;
      SEL_PC_SEQ: data = alu_pc_seq;
      SEL_CSR:    data = csr_data;
      default:    data = alu_data;  // ALU, MEM (not used here) and codes 6..7
    endcase
  end

endmodule

// File: rtl/gpr_wb_ctrl.sv
// GPR writeback controller: accepts retiring instructions, waits for load data, drives one registered write.
// Optional WB_FWD_EN: in WRITE a matching query is bypassed via fwd_* outputs instead of stalling.
module gpr_wb_ctrl
  import wb_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_wen,
  input  logic [4:0]      ex_rd,
  input  logic [2:0]      ex_wb_sel,
  input  logic [XLEN-1:0] alu_data,
  input  logic [XLEN-1:0] alu_pc_out,
  input  logic [XLEN-1:0] imme,
  input  logic [XLEN-1:0] alu_pc_seq,
  input  logic [XLEN-1:0] csr_data,
  input  logic            mem_rvalid,
  input  logic            mem_rerr,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  output logic            haz_rs1,
  output logic            haz_rs2,
`ifdef WB_FWD_EN
  output logic            fwd_rs1_vld,
  output logic            fwd_rs2_vld,
  output logic [XLEN-1:0] fwd_data,
`endif
  output logic            wb_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(MEM_TIMEOUT - 1);

  wb_state_e       state_q, state_d;
  logic            pend_vld_q, pend_vld_d;
  logic [4:0]      pend_rd_q, pend_rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            rf_wen_q, rf_wen_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            wb_err_q, wb_err_d;

  logic [XLEN-1:0] mux_data;
  logic            accept;

  wb_data_mux #(.XLEN(XLEN)) u_mux (
    .sel        (ex_wb_sel),
    .alu_data   (alu_data),
    .alu_pc_out (alu_pc_out),
    .imme       (imme),
    .alu_pc_seq (alu_pc_seq),
    .csr_data   (csr_data),
    .data       (mux_data)
  );

  assign ex_ready = (state_q == IDLE) | (state_q == WRITE);
  assign accept   = ex_valid & ex_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      pend_vld_q <= 1'b0;
      pend_rd_q  <= 5'd0;
      cnt_q      <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_rd_q  <= pend_rd_d;
      cnt_q      <= cnt_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wb_err_q   <= wb_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    pend_rd_d  = pend_rd_q;
    cnt_d      = cnt_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    wb_err_d   = 1'b0;

    case (state_q)
      IDLE, WRITE: begin
        // The pending entry of a finishing write retires here unless replaced by a new accept.
        state_d    = IDLE;
        pend_vld_d = 1'b0;
        if (accept && rd_writes(ex_wen, ex_rd)) begin
          pend_vld_d = 1'b1;
          pend_rd_d  = ex_rd;
          if (ex_wb_sel == SEL_MEM) begin
            state_d = WAIT_MEM;
            cnt_d   = '0;
          end else begin
            state_d    = WRITE;
            rf_wen_d   = 1'b1;
            rf_waddr_d = ex_rd;
            rf_wdata_d = mux_data;
          end
        end
      end
      WAIT_MEM: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response on the terminal-count cycle takes priority over the timeout.
        if (mem_rvalid) begin
          if (mem_rerr) begin
            wb_err_d   = 1'b1;
            state_d    = IDLE;
            pend_vld_d = 1'b0;
          end else begin
            state_d    = WRITE;
            rf_wen_d   = 1'b1;
            rf_waddr_d = pend_rd_q;
            rf_wdata_d = mem_rdata;
          end
        end else if (cnt_q == CNT_TERM) begin
          wb_err_d   = 1'b1;
          state_d    = IDLE;
          pend_vld_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        pend_vld_d = 1'b0;
      end
    endcase
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign wb_err   = wb_err_q;

  logic pend_live, match_rs1, match_rs2, in_write;

  assign in_write  = (state_q == WRITE);
  assign pend_live = pend_vld_q & ((state_q == WAIT_MEM) | in_write);
  assign match_rs1 = pend_live & (q_rs1 == pend_rd_q) & (q_rs1 != 5'd0);
  assign match_rs2 = pend_live & (q_rs2 == pend_rd_q) & (q_rs2 != 5'd0);

`ifdef WB_FWD_EN
  assign haz_rs1     = match_rs1 & ~in_write;
  assign haz_rs2     = match_rs2 & ~in_write;
  assign fwd_rs1_vld = match_rs1 & in_write;
  assign fwd_rs2_vld = match_rs2 & in_write;
  assign fwd_data    = rf_wdata_q;
`else
  assign haz_rs1 = match_rs1;
  assign haz_rs2 = match_rs2;
`endif

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Directed bench for gpr_wb_ctrl: table of single-instruction vectors plus load/timeout/reset sequences.
module tb_gpr_wb_ctrl;
  import wb_pkg::*;

  localparam int XLEN = 32;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn;
  logic            ex_valid, ex_ready, ex_wen;
  logic [4:0]      ex_rd;
  logic [2:0]      ex_wb_sel;
  logic [XLEN-1:0] alu_data, alu_pc_out, imme, alu_pc_seq, csr_data;
  logic            mem_rvalid, mem_rerr;
  logic [XLEN-1:0] mem_rdata;
  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [4:0]      q_rs1, q_rs2;
  logic            haz_rs1, haz_rs2, wb_err;
`ifdef WB_FWD_EN
  logic            fwd_rs1_vld, fwd_rs2_vld;
  logic [XLEN-1:0] fwd_data;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpr_wb_ctrl #(.XLEN(XLEN), .MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_wen     (ex_wen),
    .ex_rd      (ex_rd),
    .ex_wb_sel  (ex_wb_sel),
    .alu_data   (alu_data),
    .alu_pc_out (alu_pc_out),
    .imme       (imme),
    .alu_pc_seq (alu_pc_seq),
    .csr_data   (csr_data),
    .mem_rvalid (mem_rvalid),
    .mem_rerr   (mem_rerr),
    .mem_rdata  (mem_rdata),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .q_rs1      (q_rs1),
    .q_rs2      (q_rs2),
    .haz_rs1    (haz_rs1),
    .haz_rs2    (haz_rs2),
`ifdef WB_FWD_EN
    .fwd_rs1_vld(fwd_rs1_vld),
    .fwd_rs2_vld(fwd_rs2_vld),
    .fwd_data   (fwd_data),
`endif
    .wb_err     (wb_err)
  );

  typedef struct {
    logic        valid;
    logic        wen;
    logic [4:0]  rd;
    logic [2:0]  sel;
    logic [31:0] alu;
    logic        exp_wen;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wen, input logic [4:0] rd, input logic [2:0] sel);
    ex_valid  = 1'b1;
    ex_wen    = wen;
    ex_rd     = rd;
    ex_wb_sel = sel;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 5'd5,  3'd0, 32'h0000_1234, 1'b1, 5'd5,  32'h0000_1234};
    vecs[1]  = '{1'b1, 1'b1, 5'd6,  3'd1, 32'h0000_0001, 1'b1, 5'd6,  32'h0000_1000};
    vecs[2]  = '{1'b1, 1'b1, 5'd31, 3'd2, 32'h0000_0002, 1'b1, 5'd31, 32'hABCD_E000};
    vecs[3]  = '{1'b1, 1'b1, 5'd1,  3'd3, 32'h0000_0003, 1'b1, 5'd1,  32'h8000_0008};
    vecs[4]  = '{1'b1, 1'b1, 5'd2,  3'd4, 32'h0000_0004, 1'b1, 5'd2,  32'h0000_0300};
    vecs[5]  = '{1'b1, 1'b1, 5'd4,  3'd6, 32'hAAAA_5555, 1'b1, 5'd4,  32'hAAAA_5555};
    vecs[6]  = '{1'b1, 1'b1, 5'd8,  3'd7, 32'h0000_0F0F, 1'b1, 5'd8,  32'h0000_0F0F};
    vecs[7]  = '{1'b1, 1'b1, 5'd0,  3'd0, 32'h0000_0077, 1'b0, 5'd8,  32'h0000_0F0F};
    vecs[8]  = '{1'b1, 1'b0, 5'd10, 3'd0, 32'h0000_0088, 1'b0, 5'd8,  32'h0000_0F0F};
    vecs[9]  = '{1'b0, 1'b1, 5'd11, 3'd0, 32'h0000_0099, 1'b0, 5'd8,  32'h0000_0F0F};
    vecs[10] = '{1'b1, 1'b0, 5'd12, 3'd5, 32'h0000_0055, 1'b0, 5'd8,  32'h0000_0F0F};

    rstn = 1'b0;
    ex_valid = 1'b0; ex_wen = 1'b0; ex_rd = 5'd0; ex_wb_sel = 3'd0;
    alu_data = 32'h0; alu_pc_out = 32'h0000_1000; imme = 32'hABCD_E000;
    alu_pc_seq = 32'h8000_0008; csr_data = 32'h0000_0300;
    mem_rvalid = 1'b0; mem_rerr = 1'b0; mem_rdata = 32'h0;
    q_rs1 = 5'd0; q_rs2 = 5'd0;

    // Reset state
    step(); step();
    check("rst_ex_ready", 32'(ex_ready), 32'd1);
    check("rst_rf_wen",   32'(rf_wen),   32'd0);
    check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    check("rst_rf_wdata", rf_wdata,      32'd0);
    check("rst_wb_err",   32'(wb_err),   32'd0);
    check("rst_haz_rs1",  32'(haz_rs1),  32'd0);
    $display("txn reset: ex_ready=%0b rf_wen=%0b", ex_ready, rf_wen);
    rstn = 1'b1;
    step();

    // Table-driven single instructions from IDLE
    for (int i = 0; i < 11; i++) begin
      ex_valid  = vecs[i].valid;
      ex_wen    = vecs[i].wen;
      ex_rd     = vecs[i].rd;
      ex_wb_sel = vecs[i].sel;
      alu_data  = vecs[i].alu;
      q_rs1     = vecs[i].rd;
      step();
      ex_valid = 1'b0;
      $display("txn vec%0d rd=%0d sel=%0d: rf_wen=%0b waddr=%0d wdata=0x%08h",
               i, vecs[i].rd, vecs[i].sel, rf_wen, rf_waddr, rf_wdata);
      check($sformatf("vec%0d_wen", i),   32'(rf_wen),   32'(vecs[i].exp_wen));
      check($sformatf("vec%0d_waddr", i), 32'(rf_waddr), 32'(vecs[i].exp_waddr));
      check($sformatf("vec%0d_wdata", i), rf_wdata,      vecs[i].exp_wdata);
      check($sformatf("vec%0d_ready", i), 32'(ex_ready), 32'd1);
      check($sformatf("vec%0d_haz", i),   32'(haz_rs1),  32'(vecs[i].exp_wen && !FWD));
      step();
      check($sformatf("vec%0d_wen_drop", i), 32'(rf_wen), 32'd0);
    end

    // Load rd=7, response three edges after accept
    q_rs1 = 5'd7; q_rs2 = 5'd0;
    issue(1'b1, 5'd7, SEL_MEM);
    step();
    ex_valid = 1'b0;
    check("ld_ready_wait", 32'(ex_ready), 32'd0);
    check("ld_haz1_c1",    32'(haz_rs1),  32'd1);
    check("ld_haz2_x0",    32'(haz_rs2),  32'd0);
    check("ld_no_wen_c1",  32'(rf_wen),   32'd0);
    step();
    check("ld_haz1_c2",    32'(haz_rs1),  32'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FF80;
    check("ld_haz1_c3",    32'(haz_rs1),  32'd1);
    step();
    mem_rvalid = 1'b0;
    q_rs2 = 5'd7;
    #1;
    $display("txn load rd=7: rf_wen=%0b waddr=%0d wdata=0x%08h", rf_wen, rf_waddr, rf_wdata);
    check("ld_wen",   32'(rf_wen),   32'd1);
    check("ld_waddr", 32'(rf_waddr), 32'd7);
    check("ld_wdata", rf_wdata,      32'hFFFF_FF80);
    check("ld_haz1_write", 32'(haz_rs1), 32'(!FWD));
    check("ld_haz2_write", 32'(haz_rs2), 32'(!FWD));
`ifdef WB_FWD_EN
    check("ld_fwd2_vld",  32'(fwd_rs2_vld), 32'd1);
    check("ld_fwd_data",  fwd_data,         32'hFFFF_FF80);
`endif
    step();
    check("ld_wen_drop",  32'(rf_wen),   32'd0);
    check("ld_haz_clear", 32'(haz_rs1),  32'd0);
    check("ld_waddr_hold", 32'(rf_waddr), 32'd7);

    // Load rd=3 with error response
    q_rs1 = 5'd3; q_rs2 = 5'd0;
    issue(1'b1, 5'd3, SEL_MEM);
    step();
    ex_valid = 1'b0;
    check("err_haz_wait", 32'(haz_rs1), 32'd1);
    mem_rvalid = 1'b1; mem_rerr = 1'b1; mem_rdata = 32'h1111_1111;
    step();
    mem_rvalid = 1'b0; mem_rerr = 1'b0;
    $display("txn load-err rd=3: wb_err=%0b rf_wen=%0b", wb_err, rf_wen);
    check("err_pulse",  32'(wb_err),   32'd1);
    check("err_no_wen", 32'(rf_wen),   32'd0);
    check("err_haz",    32'(haz_rs1),  32'd0);
    check("err_ready",  32'(ex_ready), 32'd1);
    step();
    check("err_pulse_end", 32'(wb_err), 32'd0);

    // mem_rvalid in IDLE is ignored
    mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
    step();
    mem_rvalid = 1'b0;
    check("stray_rvalid_wen",   32'(rf_wen),   32'd0);
    check("stray_rvalid_wdata", rf_wdata,      32'hFFFF_FF80);

    // Timeout: no response for 4 cycles in WAIT_MEM
    q_rs1 = 5'd12;
    issue(1'b1, 5'd12, SEL_MEM);
    step();
    ex_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      check($sformatf("to_wait%0d_err", c),   32'(wb_err),   32'd0);
      check($sformatf("to_wait%0d_ready", c), 32'(ex_ready), 32'd0);
    end
    step();
    $display("txn timeout rd=12: wb_err=%0b ex_ready=%0b", wb_err, ex_ready);
    check("to_err",    32'(wb_err),   32'd1);
    check("to_ready",  32'(ex_ready), 32'd1);
    check("to_no_wen", 32'(rf_wen),   32'd0);
    check("to_haz",    32'(haz_rs1),  32'd0);
    step();
    check("to_err_end", 32'(wb_err), 32'd0);

    // Response on the terminal-count cycle beats the timeout
    issue(1'b1, 5'd13, SEL_MEM);
    step();
    ex_valid = 1'b0;
    step(); step(); step();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_00AB;
    step();
    mem_rvalid = 1'b0;
    $display("txn load-tc rd=13: rf_wen=%0b wb_err=%0b wdata=0x%08h", rf_wen, wb_err, rf_wdata);
    check("tc_wen",   32'(rf_wen),   32'd1);
    check("tc_err",   32'(wb_err),   32'd0);
    check("tc_waddr", 32'(rf_waddr), 32'd13);
    check("tc_wdata", rf_wdata,      32'h0000_00AB);
    step();

    // Back-to-back accepts: x0, x9, jal x1, ecall
    issue(1'b1, 5'd0, SEL_ALU); alu_data = 32'h0000_0050;
    step();
    check("b2b_x0_wen", 32'(rf_wen), 32'd0);
    issue(1'b1, 5'd9, SEL_ALU); alu_data = 32'h0000_0099;
    step();
    check("b2b_x9_wen",   32'(rf_wen),   32'd1);
    check("b2b_x9_waddr", 32'(rf_waddr), 32'd9);
    check("b2b_x9_wdata", rf_wdata,      32'h0000_0099);
    issue(1'b1, 5'd1, SEL_PC_SEQ);
    step();
    check("b2b_jal_wen",   32'(rf_wen),   32'd1);
    check("b2b_jal_waddr", 32'(rf_waddr), 32'd1);
    check("b2b_jal_wdata", rf_wdata,      32'h8000_0008);
    issue(1'b0, 5'd0, SEL_ALU);
    step();
    ex_valid = 1'b0;
    $display("txn b2b ecall: rf_wen=%0b waddr=%0d", rf_wen, rf_waddr);
    check("b2b_ecall_wen",  32'(rf_wen),   32'd0);
    check("b2b_ecall_hold", rf_wdata,      32'h8000_0008);
    step();

    // Reset while in WAIT_MEM drops the load
    q_rs1 = 5'd14;
    issue(1'b1, 5'd14, SEL_MEM);
    step();
    ex_valid = 1'b0;
    check("rw_pre_haz", 32'(haz_rs1), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("rw_ready",  32'(ex_ready), 32'd1);
    check("rw_haz",    32'(haz_rs1),  32'd0);
    check("rw_waddr",  32'(rf_waddr), 32'd0);
    check("rw_wdata",  rf_wdata,      32'd0);
    step();
    rstn = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h3333_3333;
    step();
    mem_rvalid = 1'b0;
    $display("txn reset-in-wait: rf_wen=%0b ex_ready=%0b", rf_wen, ex_ready);
    check("rw_late_rvalid_wen", 32'(rf_wen),   32'd0);
    check("rw_late_ready",      32'(ex_ready), 32'd1);
    check("rw_late_err",        32'(wb_err),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
